// File: rtl/simd_div_pkg.sv
// +----------------------------------------------------------------------------+
// | simd_div_pkg                                                               |
// | Shared types and lane-geometry helpers for the packed SIMD divider.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package simd_div_pkg;

  typedef enum logic [1:0] {
    MODE_8 = 2'd0,
    MODE_4 = 2'd1,
    MODE_2 = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] msb;
    logic [7:0] lsb;
  } lane_mask_t;

  function automatic logic [3:0] lane_w(input mode_t mode);
    case (mode)
      MODE_8:  lane_w = 4'd8;
      MODE_4:  lane_w = 4'd4;
      default: lane_w = 4'd2;
    endcase
  endfunction

  function automatic lane_mask_t lane_mask(input mode_t mode);
    case (mode)
      MODE_8:  lane_mask = '{msb: 8'h80, lsb: 8'h01};
      MODE_4:  lane_mask = '{msb: 8'h88, lsb: 8'h11};
      default: lane_mask = '{msb: 8'hAA, lsb: 8'h55};
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/simd_div_step.sv
// +----------------------------------------------------------------------------+
// | simd_div_step                                                              |
// | One restoring-division iteration applied to every lane of the 8-bit bus.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module simd_div_step
  import simd_div_pkg::*;
(
  input  lane_mask_t  mask,
  input  logic [7:0]  dvd_in,
  input  logic [7:0]  rem_in,
  input  logic [7:0]  div_in,
  output logic [7:0]  dvd_out,
  output logic [7:0]  rem_out
);

  logic [7:0] w_dvd_top;
  logic [7:0] w_rem_top;
  logic [7:0] w_rem_sh;
  logic [7:0] w_diff;
  logic [7:0] w_lane_ge;
  logic [7:0] w_ge;
  logic       w_dtop;
  logic       w_rtop;
  logic       w_borrow;
  logic       w_ge_cur;

  always_comb begin
    w_dvd_top = '0;
    w_rem_top = '0;
    w_rem_sh  = '0;
    w_diff    = '0;
    w_lane_ge = '0;
    w_ge      = '0;
    w_dtop    = 1'b0;
    w_rtop    = 1'b0;
    w_borrow  = 1'b0;
    w_ge_cur  = 1'b0;

    // Spread each lane's dividend MSB and the remainder bit shifted out (the
    // (W+1)th bit of the partial remainder) across the lane.
    for (int i = 7; i >= 0; i--) begin
      if (mask.msb[i]) begin
        w_dtop = dvd_in[i];
        w_rtop = rem_in[i];
      end
      w_dvd_top[i] = w_dtop;
      w_rem_top[i] = w_rtop;
    end

    w_rem_sh = ({rem_in[6:0], 1'b0} & ~mask.lsb) | (w_dvd_top & mask.lsb);

    // Borrow chain restarts at every lane LSB so nothing crosses a lane.
    for (int i = 0; i < 8; i++) begin
      if (mask.lsb[i]) begin
        w_borrow = 1'b0;
      end
      w_diff[i] = w_rem_sh[i] ^ div_in[i] ^ w_borrow;
      w_borrow  = (~w_rem_sh[i] & div_in[i]) | (~(w_rem_sh[i] ^ div_in[i]) & w_borrow);
      if (mask.msb[i]) begin
        w_lane_ge[i] = w_rem_top[i] | ~w_borrow;
      end
    end

    for (int i = 7; i >= 0; i--) begin
      if (mask.msb[i]) begin
        w_ge_cur = w_lane_ge[i];
      end
      w_ge[i] = w_ge_cur;
    end

    // Quotient bits enter the vacated dividend LSBs.
    dvd_out = ({dvd_in[6:0], 1'b0} & ~mask.lsb) | (w_ge & mask.lsb);
    rem_out = (w_ge & w_diff) | (~w_ge & w_rem_sh);
  end

endmodule

`default_nettype wire

// File: rtl/simd_div_seq.sv
// +----------------------------------------------------------------------------+
// | simd_div_seq                                                               |
// | Sequential unsigned SIMD restoring divider (8/4/2-bit lanes), valid/ready. |
// | Option: SIMD_DIV_DZFLAG_EN adds per-lane divide-by-zero flags (divzero).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module simd_div_seq
  import simd_div_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dividea,
  input  logic [DATA_W-1:0] divideb,
  input  logic              H,
  input  logic              X,
  input  logic              C,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotoutput,
  output logic [DATA_W-1:0] remoutput
`ifdef SIMD_DIV_DZFLAG_EN
  ,
  output logic [3:0]        divzero
`endif
);

  localparam int c_iter_shift = (ITER_PER_CYCLE == 2) ? 1 : 0;

  if (DATA_W != 8) begin : g_bad_data_w
    $error("simd_div_seq: DATA_W must be 8");
  end
  if (ITER_PER_CYCLE != 1 && ITER_PER_CYCLE != 2) begin : g_bad_iter
    $error("simd_div_seq: ITER_PER_CYCLE must be 1 or 2");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  mode_t      r_mode;
  mode_t      w_mode;
  logic [3:0] r_cnt;
  logic [7:0] r_dvd;
  logic [7:0] r_rem;
  logic [7:0] r_div;
  lane_mask_t w_mask;

  logic [7:0] w_dvd_ch [ITER_PER_CYCLE+1];
  logic [7:0] w_rem_ch [ITER_PER_CYCLE+1];

  // H has priority over X; C (or no mode bit at all) selects 2-bit lanes.
  always_comb begin
    w_mode = MODE_2;
    casez ({H, X, C})
      3'b1??:  w_mode = MODE_8;
      3'b01?:  w_mode = MODE_4;
      3'b001:  w_mode = MODE_2;
      default: w_mode = MODE_2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_mask      = lane_mask(r_mode);
  assign w_dvd_ch[0] = r_dvd;
  assign w_rem_ch[0] = r_rem;

  for (genvar k = 0; k < ITER_PER_CYCLE; k++) begin : g_iter
    simd_div_step u_step (
      .mask    (w_mask),
      .dvd_in  (w_dvd_ch[k]),
      .rem_in  (w_rem_ch[k]),
      .div_in  (r_div),
      .dvd_out (w_dvd_ch[k+1]),
      .rem_out (w_rem_ch[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= MODE_8;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      quotoutput <= '0;
      remoutput  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd  <= dividea;
            r_div  <= divideb;
            r_rem  <= '0;
            r_mode <= w_mode;
            r_cnt  <= lane_w(w_mode) >> c_iter_shift;
          end
        end
        CALC: begin
          r_dvd <= w_dvd_ch[ITER_PER_CYCLE];
          r_rem <= w_rem_ch[ITER_PER_CYCLE];
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            quotoutput <= w_dvd_ch[ITER_PER_CYCLE];
            remoutput  <= w_rem_ch[ITER_PER_CYCLE];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SIMD_DIV_DZFLAG_EN
  logic [3:0] w_dz;

  always_comb begin
    w_dz = '0;
    case (r_mode)
      MODE_8:  w_dz = {3'b000, r_div == 8'd0};
      MODE_4:  w_dz = {2'b00, r_div[7:4] == 4'd0, r_div[3:0] == 4'd0};
      default: w_dz = {r_div[7:6] == 2'd0, r_div[5:4] == 2'd0,
                       r_div[3:2] == 2'd0, r_div[1:0] == 2'd0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divzero <= '0;
    end else if (r_state == CALC && r_cnt == 4'd1) begin
      divzero <= w_dz;
    end
  end
`endif

endmodule

`default_nettype wire
